// File: rtl/dram_controller.sv
// DRAM controller for a 32-bit CPU bus: RAS/CAS sequencing, byte-lane
// column strobes, port-size acknowledge and periodic CAS-before-RAS refresh.
// Every output is a register loaded from the next-state decode of one FSM.
module dram_controller #(
   parameter int unsigned REFRESH_INTERVAL = 780
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        CS_DRAM_n,
   input  logic        AS_n,
   input  logic        RW,
   input  logic        SIZ0,
   input  logic        SIZ1,
   input  logic [21:0] A,
   output logic [9:0]  MA,
   output logic        RAS_n,
   output logic [3:0]  CAS_n,
   output logic        WE_n,
   output logic        DSACK0_DRAM_n,
   output logic        DSACK1_DRAM_n
);

   localparam int unsigned CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      ROW   = 4'd1,
      RCD   = 4'd2,
      CAS   = 4'd3,
      PRE1  = 4'd4,
      PRE2  = 4'd5,
      RCAS  = 4'd6,
      RRAS1 = 4'd7,
      RRAS2 = 4'd8,
      RRAS3 = 4'd9
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic [9:0]    ma_q, ma_d;
   logic          ras_q, ras_d;
   logic [3:0]    cas_q, cas_d;
   logic          we_q, we_d;
   logic          dsack_q, dsack_d;

   // Active-low column strobes for a write, from the byte offset and transfer
   // size. Bit order is {UUD, UMD, LMD, LLD} = {D31:24, D23:16, D15:8, D7:0}.
   function automatic logic [3:0] write_cas_n(input logic a1, input logic a0,
                                              input logic siz1, input logic siz0);
      logic uud, umd, lmd, lld;
      uud = ~a1 & ~a0;
      umd = (~a1 & a0) | (~a1 & ~siz0) | (~a1 & siz1);
      lmd = (a1 & ~a0) | (~a1 & ~siz0 & ~siz1) | (~a1 & siz0 & siz1) | (~a1 & a0 & ~siz0);
      lld = (a1 & a0) | (a0 & siz0 & siz1) | (~siz0 & ~siz1) | (a1 & siz1);
      return ~{uud, umd, lmd, lld};
   endfunction

   // State, refresh bookkeeping and output registers; reset aborts any cycle.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= IDLE;
         cnt_q   <= RELOAD;
         pend_q  <= 1'b0;
         ma_q    <= 10'd0;
         ras_q   <= 1'b1;
         cas_q   <= 4'b1111;
         we_q    <= 1'b1;
         dsack_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ma_q    <= ma_d;
         ras_q   <= ras_d;
         cas_q   <= cas_d;
         we_q    <= we_d;
         dsack_q <= dsack_d;
      end
   end

   // Refresh timer: an expiry always (re)sets the request, even in RCAS,
   // so a request arriving while one is serviced is never lost.
   always_comb begin
      cnt_d  = cnt_q;
      pend_d = pend_q;
      if (cnt_q == {CW{1'b0}}) begin
         cnt_d  = RELOAD;
         pend_d = 1'b1;
      end else begin
         cnt_d = cnt_q - CW'(1'b1);
         if (state_q == RCAS) begin
            pend_d = 1'b0;
         end else begin
            pend_d = pend_q;
         end
      end
   end

   // Next-state decode; refresh has priority over a CPU access in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               state_d = RCAS;
            end else if (!CS_DRAM_n && !AS_n) begin
               state_d = ROW;
            end else begin
               state_d = IDLE;
            end
         end
         ROW:   state_d = AS_n ? PRE1 : RCD;
         RCD:   state_d = AS_n ? PRE1 : CAS;
         CAS:   state_d = AS_n ? PRE1 : CAS;
         PRE1:  state_d = PRE2;
         PRE2:  state_d = IDLE;
         RCAS:  state_d = RRAS1;
         RRAS1: state_d = RRAS2;
         RRAS2: state_d = RRAS3;
         RRAS3: state_d = PRE1;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the state being entered; MA only moves at row/column load.
   always_comb begin
      ma_d    = ma_q;
      ras_d   = 1'b1;
      cas_d   = 4'b1111;
      we_d    = 1'b1;
      dsack_d = 1'b1;
      case (state_d)
         ROW: begin
            ras_d = 1'b0;
            we_d  = RW;
            ma_d  = A[21:12];
         end
         RCD: begin
            ras_d = 1'b0;
            we_d  = we_q;
            ma_d  = A[11:2];
         end
         CAS: begin
            ras_d   = 1'b0;
            we_d    = we_q;
            dsack_d = 1'b0;
            if (state_q == CAS) begin
               cas_d = cas_q;
            end else if (we_q) begin
               cas_d = 4'b0000;
            end else begin
               cas_d = write_cas_n(A[1], A[0], SIZ1, SIZ0);
            end
         end
         RCAS: begin
            cas_d = 4'b0000;
         end
         RRAS1, RRAS2, RRAS3: begin
            ras_d = 1'b0;
            cas_d = 4'b0000;
         end
         default: begin
            ras_d = 1'b1;
         end
      endcase
   end

   assign MA            = ma_q;
   assign RAS_n         = ras_q;
   assign CAS_n         = cas_q;
   assign WE_n          = we_q;
   assign DSACK0_DRAM_n = dsack_q;
   assign DSACK1_DRAM_n = dsack_q;

endmodule

// File: doc/dram_controller.md
DRAM_CONTROLLER -- requirements
Module: dram_controller

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 780, meaning the number of CLK cycles between refresh requests (15.6 us at 50 MHz).
REQ-002 SHALL have port CLK, input, 1 bit: system clock; all state changes occur on the rising edge.
REQ-003 SHALL have port RST_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port CS_DRAM_n, input, 1 bit: DRAM select from the system controller (0xC0000000); it is not qualified by AS_n.
REQ-005 SHALL have port AS_n, input, 1 bit: CPU address strobe.
REQ-006 SHALL have port RW, input, 1 bit: 1 = read, 0 = write.
REQ-007 SHALL have ports SIZ0 and SIZ1, input, 1 bit each: CPU transfer size.
REQ-008 SHALL have port A, input, 22 bits [21:0]: CPU address.
REQ-009 SHALL have port MA, output, 10 bits: multiplexed DRAM address.
REQ-010 SHALL have port RAS_n, output, 1 bit: row strobe.
REQ-011 SHALL have port CAS_n, output, 4 bits [3:0]: column strobes; bit 3 = D31:24 (UUD), bit 2 = UMD, bit 1 = LMD, bit 0 = D7:0 (LLD).
REQ-012 SHALL have port WE_n, output, 1 bit: DRAM write enable.
REQ-013 SHALL have ports DSACK0_DRAM_n and DSACK1_DRAM_n, output, 1 bit each: port-size acknowledge to the system controller.

Function
REQ-014 SHALL register all outputs and drive them from a single state machine with states IDLE, ROW, RCD, CAS, PRE1, PRE2, RCAS, RRAS1, RRAS2, RRAS3.
REQ-015 SHALL decrement a refresh counter every cycle; when it reaches 0, it SHALL set refresh_pending and reload REFRESH_INTERVAL-1.
REQ-016 SHALL leave refresh_pending set if a further expiry occurs while it is already set; requests are not queued.
REQ-017 In IDLE, SHALL go to RCAS if refresh_pending is set; refresh wins over a simultaneous access.
REQ-018 In IDLE, SHALL go to ROW when CS_DRAM_n=0 and AS_n=0 are sampled and refresh_pending is clear.
REQ-019 On the IDLE->ROW edge, SHALL drive RAS_n=0 and MA=A[21:12], and SHALL set WE_n=RW.
REQ-020 ROW SHALL last 1 cycle and go to RCD; RCD SHALL drive MA=A[11:2] and last 1 cycle.
REQ-021 On entering CAS (2 edges after the request is sampled), SHALL drive DSACK0_DRAM_n=0 and DSACK1_DRAM_n=0 (32-bit port).
REQ-022 On entering CAS for a read, SHALL drive CAS_n=4'b0000.
REQ-023 On entering CAS for a write, SHALL drive CAS_n low per lane, where CAS_n[i]=~lane_i:
- UUD = ~A1&~A0
- UMD = ~A1&A0 | ~A1&~SIZ0 | ~A1&SIZ1
- LMD = A1&~A0 | ~A1&~SIZ0&~SIZ1 | ~A1&SIZ0&SIZ1 | ~A1&A0&~SIZ0
- LLD = A1&A0 | A0&SIZ0&SIZ1 | ~SIZ0&~SIZ1 | A1&SIZ1
REQ-024 SHALL hold CAS until AS_n=1 is sampled, then go to PRE1; RAS_n, CAS_n, WE_n, DSACK0_DRAM_n and DSACK1_DRAM_n SHALL all be 1 from PRE1 onward.
REQ-025 SHALL go from ROW or RCD to PRE1 if AS_n=1 is sampled there (aborted cycle), without asserting CAS_n or DSACK.
REQ-026 PRE1 SHALL be followed by PRE2 and then IDLE; a new access or refresh SHALL NOT start before IDLE (minimum 2-cycle RAS precharge).
REQ-027 Refresh (CAS-before-RAS) SHALL proceed as follows:
- RCAS: CAS_n=0000, RAS_n=1, and refresh_pending cleared.
- RRAS1..RRAS3: RAS_n=0 and CAS_n=0000.
- then PRE1.
- WE_n=1 and both DSACK outputs =1 throughout.
REQ-028 An access arriving during refresh or precharge SHALL wait; the CPU holds AS_n with no DSACK, and the access is taken in IDLE.
REQ-029 If a counter expiry coincides with the RCAS cycle, refresh_pending SHALL remain set.
REQ-030 SHALL keep MA stable while RAS_n=0, except at the RCD row-to-column switch.

Reset
REQ-031 While RST_n=0, SHALL immediately force RAS_n=1, CAS_n=4'b1111, WE_n=1, DSACK0_DRAM_n=1, DSACK1_DRAM_n=1, MA=0, state=IDLE, refresh_pending=0, and counter=REFRESH_INTERVAL-1, including during an in-progress cycle.
REQ-032 After RST_n rises, the first refresh SHALL occur REFRESH_INTERVAL cycles later unless an access intervenes.

Verification
REQ-033 Long read at 0xC0001234: RAS_n low after edge 1 with MA=0x001; CAS_n=0000 and both DSACK low after edge 3 with MA=0x08D; all outputs high 1 edge after AS_n rises; IDLE after 2 more edges.
REQ-034 Byte write with A[1:0]=01, SIZ=01: CAS_n=4'b1011 and WE_n=0; word write with A[1:0]=10, SIZ=10: CAS_n=4'b1100.
REQ-035 Refresh and access requested in the same IDLE cycle: RCAS first, then 3 RRAS cycles and 2 PRE cycles; ROW follows, and DSACK goes low 9 cycles after the request is sampled.
REQ-036 REFRESH_INTERVAL=16 with idle bus: CBR refresh every 16 cycles, with CAS_n falling exactly 1 cycle before RAS_n each time.
REQ-037 RST_n pulsed low while in CAS: all strobes and DSACK high within the same cycle; no refresh until 16 cycles after release (REFRESH_INTERVAL=16).
REQ-038 AS_n negated while in RCD: CAS_n never asserts, DSACK stays high, and the PRE1-PRE2-IDLE sequence follows.
